// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared state encoding and sizing helpers for poly_solver
package poly_pkg;

    localparam int MAX_DEG = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Counter must hold DEG itself; a degree-0 build still needs a 1-bit counter.
    function automatic int cnt_width(input int deg);
        return (deg < 1) ? 1 : $clog2(deg + 1);
    endfunction

endpackage

// File: rtl/horner_step.sv
// rtl/horner_step.sv - one Horner multiply-add with full-precision overflow detect
module horner_step #(
    parameter int XW = 8,
    parameter int W  = 16
) (
    input  logic [W-1:0]  acc_i,
    input  logic [XW-1:0] x_i,
    input  logic [W-1:0]  coef_i,
    output logic [W-1:0]  sum_o,
    output logic          ovf_o
);

    // acc*x < 2^(W+XW) and coef < 2^W, so one extra bit holds the sum exactly.
    localparam int FW = W + XW + 1;

    logic [FW-1:0] full;

    assign full  = FW'(acc_i) * FW'(x_i) + FW'(coef_i);
    assign sum_o = full[W-1:0];
    assign ovf_o = |full[FW-1:W];

endmodule

// File: rtl/poly_solver.sv
// rtl/poly_solver.sv - sequential Horner polynomial evaluator, one step per clock
module poly_solver
    import poly_pkg::*;
#(
    parameter int XW  = 8,
    parameter int W   = 16,
    parameter int DEG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XW-1:0]        x,
    input  logic [(DEG+1)*W-1:0] coef,
    output logic [W-1:0]         result,
    output logic                 zero,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = cnt_width(DEG);

    state_e               state_q;
    logic [XW-1:0]        x_q;
    logic [(DEG+1)*W-1:0] coef_q;
    logic [W-1:0]         acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 sticky_q;
    logic [W-1:0]         result_q;
    logic                 zero_q;
    logic                 overflow_q;
    logic                 busy_q;
    logic                 done_q;

    logic [W-1:0]         coef_sel;
    logic [W-1:0]         step_sum;
    logic                 step_ovf;

    // cnt_q counts remaining steps; the step with cnt_q == k+1 consumes coef[k].
    always_comb begin
        coef_sel = coef_q[DEG*W +: W];
        for (int k = 0; k < DEG; k++) begin
            if (cnt_q == CW'(k + 1)) begin
                coef_sel = coef_q[k*W +: W];
            end
        end
    end

    horner_step #(
        .XW (XW),
        .W  (W)
    ) u_step (
        .acc_i  (acc_q),
        .x_i    (x_q),
        .coef_i (coef_sel),
        .sum_o  (step_sum),
        .ovf_o  (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            coef_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q      <= x;
                        coef_q   <= coef;
                        acc_q    <= coef[DEG*W +: W];
                        cnt_q    <= CW'(DEG);
                        sticky_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (DEG == 0) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            result_q   <= coef[W-1:0];
                            zero_q     <= (coef[W-1:0] == '0);
                            overflow_q <= 1'b0;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q    <= step_sum;
                    sticky_q <= sticky_q | step_ovf;
                    cnt_q    <= cnt_q - CW'(1);
                    // Outputs are loaded on entry to DONE so they are valid alongside done.
                    if (cnt_q == CW'(1)) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        result_q   <= step_sum;
                        zero_q     <= (step_sum == '0);
                        overflow_q <= sticky_q | step_ovf;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_poly_solver.sv
// tb/tb_poly_solver.sv - randomized self-checking bench for poly_solver
module tb_poly_solver;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  x;
    logic [47:0] coef;
    logic [15:0] result;
    logic        zero;
    logic        overflow;
    logic        busy;
    logic        done;

    logic        start0;
    logic [7:0]  x0;
    logic [15:0] coef0;
    logic [15:0] result0;
    logic        zero0;
    logic        overflow0;
    logic        busy0;
    logic        done0;

    int tests;
    int fails;
    int cyc;

    poly_solver #(.XW(8), .W(16), .DEG(2)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .coef(coef),
        .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
    );

    poly_solver #(.XW(8), .W(16), .DEG(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x(x0), .coef(coef0),
        .result(result0), .zero(zero0), .overflow(overflow0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Value of the polynomial as a plain power sum, reduced mod 2^16.
    function automatic logic [15:0] model_val(input logic [7:0] xv, input logic [47:0] cv);
        longint unsigned s;
        longint unsigned p;
        s = 0;
        p = 1;
        for (int k = 0; k <= 2; k++) begin
            s = s + longint'(cv[k*16 +: 16]) * p;
            p = p * longint'(xv);
        end
        return s[15:0];
    endfunction

    // Sticky flag: any Horner stage value (before wrapping) reaching 2^16.
    function automatic logic model_ovf(input logic [7:0] xv, input logic [47:0] cv);
        longint unsigned a;
        longint unsigned v;
        logic o;
        a = longint'(cv[32 +: 16]);
        o = 1'b0;
        for (int k = 1; k >= 0; k--) begin
            v = a * longint'(xv) + longint'(cv[k*16 +: 16]);
            if (v >= 65536) o = 1'b1;
            a = v % 65536;
        end
        return o;
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic do_eval(input logic [7:0] xv, input logic [47:0] cv, output int lat,
                           output logic [15:0] r, output logic z, output logic o,
                           output logic after_ok);
        wait_idle();
        x = xv; coef = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = 8'($urandom);
        coef = 48'({$urandom, $urandom});
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; o = overflow;
        @(posedge clk); #1;
        after_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; x = '0; coef = '0;
        start0 = 1'b0; x0 = '0; coef0 = '0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({result, zero, overflow, busy, done} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {result, zero, overflow, busy, done});
        end
        tests++;
        if ({result0, zero0, overflow0, busy0, done0} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs_deg0 got=%h exp=0", {result0, zero0, overflow0, busy0, done0});
        end
        start = 1'b0; start0 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  xs [5];
        logic [47:0] cs [5];
        int lat;
        logic [15:0] r;
        logic z, o, ok;
        xs[0] = 8'd15;  cs[0] = {16'd96, 16'd3, 16'd1};
        xs[1] = 8'd255; cs[1] = {16'hFFFF, 16'd0, 16'd0};
        xs[2] = 8'($urandom); cs[2] = 48'h0;
        xs[3] = 8'd0;   cs[3] = {16'($urandom), 16'($urandom), 16'd7};
        xs[4] = 8'd1;   cs[4] = {16'hFFFF, 16'd1, 16'd5};
        for (int i = 0; i < 5; i++) begin
            do_eval(xs[i], cs[i], lat, r, z, o, ok);
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL vec%0d_latency got=%0d exp=3", i, lat);
            end
            tests++;
            if ({r, z, o} !== {model_val(xs[i], cs[i]), model_val(xs[i], cs[i]) == 16'h0, model_ovf(xs[i], cs[i])}) begin
                fails++;
                $display("FAIL vec%0d_result got=%h/%b/%b exp=%h/%b/%b", i, r, z, o,
                         model_val(xs[i], cs[i]), model_val(xs[i], cs[i]) == 16'h0, model_ovf(xs[i], cs[i]));
            end
            tests++;
            if (ok !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d_single_done got=%b exp=1", i, ok);
            end
        end
        tests++;
        if (model_val(8'd15, {16'd96, 16'd3, 16'd1}) !== 16'h548E || model_val(8'd255, {16'hFFFF, 32'h0}) !== 16'h01FF) begin
            fails++;
            $display("FAIL model_anchor got=%h exp=548e", model_val(8'd15, {16'd96, 16'd3, 16'd1}));
        end
    endtask

    task automatic test_random();
        logic [7:0]  xv;
        logic [47:0] cv;
        int lat;
        logic [15:0] r;
        logic z, o, ok;
        for (int i = 0; i < 25; i++) begin
            xv = 8'($urandom);
            cv = 48'({$urandom, $urandom});
            if (i % 5 == 0) cv[47:32] = 16'($urandom_range(0, 3));
            do_eval(xv, cv, lat, r, z, o, ok);
            tests++;
            if (lat !== 3 || ok !== 1'b1 || r !== model_val(xv, cv) || o !== model_ovf(xv, cv)
                || z !== (model_val(xv, cv) == 16'h0)) begin
                fails++;
                $display("FAIL rand%0d got=lat%0d/%h/%b/%b/%b exp=lat3/%h/%b/%b/1", i, lat, r, z, o, ok,
                         model_val(xv, cv), model_val(xv, cv) == 16'h0, model_ovf(xv, cv));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  xa, xb;
        logic [47:0] cv;
        int g, t1, t2;
        wait_idle();
        xa = 8'($urandom_range(2, 255));
        xb = xa ^ 8'h5A;
        cv = 48'({$urandom, $urandom});
        x = xa; coef = cv; start = 1'b1;
        @(posedge clk); #1;
        x = xb;
        g = 0;
        while (done !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
        t1 = cyc;
        tests++;
        if (result !== model_val(xa, cv)) begin
            fails++;
            $display("FAIL b2b_first got=%h exp=%h", result, model_val(xa, cv));
        end
        @(posedge clk); #1;
        g = 0;
        while (done !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
        t2 = cyc;
        start = 1'b0;
        tests++;
        if (t2 - t1 !== 4) begin
            fails++;
            $display("FAIL b2b_period got=%0d exp=4", t2 - t1);
        end
        tests++;
        if (result !== model_val(xb, cv) || overflow !== model_ovf(xb, cv)) begin
            fails++;
            $display("FAIL b2b_second got=%h/%b exp=%h/%b", result, overflow, model_val(xb, cv), model_ovf(xb, cv));
        end
        wait_idle();
    endtask

    task automatic test_reset_abort();
        int seen;
        wait_idle();
        x = 8'd15; coef = {16'd96, 16'd3, 16'd1}; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || result !== 16'h0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_state got=busy%b/%h/done%b exp=busy0/0000/done0", busy, result, done);
        end
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_done got=%0d exp=0", seen);
        end
    endtask

    task automatic test_deg0();
        logic [15:0] cvals [3];
        int lat;
        cvals[0] = 16'h1234;
        cvals[1] = 16'h0000;
        cvals[2] = 16'($urandom_range(1, 65535));
        for (int i = 0; i < 3; i++) begin
            x0 = 8'($urandom); coef0 = cvals[i]; start0 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0; coef0 = 16'($urandom);
            lat = 1;
            while (done0 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
            tests++;
            if (lat !== 1 || result0 !== cvals[i] || zero0 !== (cvals[i] == 16'h0) || overflow0 !== 1'b0) begin
                fails++;
                $display("FAIL deg0_%0d got=lat%0d/%h/%b/%b exp=lat1/%h/%b/0", i, lat, result0, zero0,
                         overflow0, cvals[i], cvals[i] == 16'h0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_deg0();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/poly_solver.md
POLY_SOLVER -- requirements
Module: poly_solver

Interface
REQ-001 Parameter XW, default 8: width of the unsigned operand x.
REQ-002 Parameter W, default 16: width of each coefficient, the accumulator and the result.
REQ-003 Parameter DEG, default 2, legal range 0..8: polynomial degree.
REQ-004 clk  in  1  the single clock; all state SHALL change on its rising edge only.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  request pulse or level, sampled only in IDLE.
REQ-007 x  in  XW  unsigned operand, captured when start is accepted.
REQ-008 coef  in  (DEG+1)*W  unsigned coefficients, coefficient k at bits [k*W +: W], captured when start is accepted.
REQ-009 result  out  W  value of the polynomial modulo 2^W.
REQ-010 zero  out  1  result equals 0.
REQ-011 overflow  out  1  a full-precision intermediate value exceeded W bits.
REQ-012 busy  out  1  an evaluation is in progress.
REQ-013 done  out  1  single-cycle completion strobe.

Function
REQ-014 The block SHALL evaluate sum(coef_k * x^k) by Horner's rule, using one multiply-add step per clock.
REQ-015 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch x and coef, load acc=coef[DEG], load cnt=DEG and clear overflow.
REQ-017 After that start, the next state SHALL be RUN if DEG>0 and DONE if DEG=0.
REQ-018 Each RUN cycle SHALL compute acc <= (acc*x + coef[cnt-1]) mod 2^W and then cnt <= cnt-1.
REQ-019 RUN SHALL go to DONE when the step that uses coef[0] completes.
REQ-020 The multiply-add SHALL be computed at W+XW+1 bits.
REQ-021 overflow SHALL be set sticky if any step's full-precision value is at or above 2^W.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-023 Latency SHALL be fixed: done is high in the cycle DEG+1 edges after start is accepted, independent of data.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 start SHALL be ignored outside IDLE, and the latched operands SHALL NOT change.
REQ-026 If start is held high, a new evaluation SHALL be accepted in the IDLE cycle after DONE, giving a back-to-back period of DEG+2 cycles.
REQ-027 result, zero and overflow SHALL be registered, updated in DONE, and held until the next DONE.
REQ-028 The input operands need not be stable after the accept cycle.

Reset
REQ-029 rst=0 at a clock edge SHALL force state IDLE, acc=0, cnt=0, result=0, zero=0, overflow=0, busy=0 and done=0.
REQ-030 rst=0 during RUN or DONE SHALL abort the evaluation with no done strobe.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 A shared package poly_pkg SHALL hold the state encoding (IDLE, RUN, DONE) and the constant MAX_DEG=8.
REQ-033 The combinational multiply-add and overflow detect SHALL be one sub-module, horner_step, parameterised by XW and W.
REQ-034 The counter width SHALL be clog2(DEG+1), with a minimum of 1.

Verification
REQ-035 Default parameters, x=15, coef={1,3,96} (k0..k2), start pulse -> done 3 cycles after accept, result=21646 (0x548E), overflow=0, zero=0.
REQ-036 x=255, coef={0,0,0xFFFF} -> result=0x01FF, overflow=1, done 3 cycles after accept.
REQ-037 All coefficients 0, any x -> result=0, zero=1; then x=0, coef0=7 -> result=7, zero=0.
REQ-038 start held high through 2 evaluations, with x changed mid-RUN -> second accept exactly 4 cycles after the first, and each result uses its own latched x.
REQ-039 rst=0 in the 2nd RUN cycle -> the next cycle shows busy=0, result=0, and no done pulse.
REQ-040 Instance with DEG=0 and coef0=0x1234 -> done 1 cycle after accept, result=0x1234.
